// File: rtl/fc_net_main.sv
// Two-layer fully-connected classifier with constant ROMs, one sequential MAC and argmax.
// Runs one inference per enable request and holds the class index until enable drops.
module fc_net_main #(
  parameter int firstLayerNodes  = 3,
  parameter int secondLayerNodes = 2,
  parameter int thirdLayerNodes  = 10,
  parameter int DATA_W           = 16,
  parameter int FRAC_W           = 8,
  parameter int W2_OVR_MASK      = 0,
  parameter logic signed [DATA_W-1:0] W2_OVR_VAL = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       finished,
  output logic [3:0] result
);

  localparam int F  = firstLayerNodes;
  localparam int S  = secondLayerNodes;
  localparam int T  = thirdLayerNodes;
  localparam int PW = 2 * DATA_W;
  localparam int AW = PW + 8;
  localparam int CW = 8;

  localparam logic signed [DATA_W-1:0] W1_VAL = DATA_W'(1 << FRAC_W);
  localparam logic signed [DATA_W-1:0] B1_VAL = '0;
  localparam logic signed [DATA_W-1:0] B2_VAL = '0;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_ARG, S_DONE} state_t;

  function automatic logic signed [DATA_W-1:0] x_rom(input int i);
    return DATA_W'((i + 1) << FRAC_W);
  endfunction

  // Row k of W2 is constant across hidden inputs; a masked row takes the override value.
  function automatic logic signed [DATA_W-1:0] w2_rom(input int k);
    if (((W2_OVR_MASK >> k) & 1) != 0) return W2_OVR_VAL;
    return DATA_W'(((T - k) << FRAC_W) >>> 2);
  endfunction

  function automatic logic signed [DATA_W-1:0] bias_shift_sat(
    input logic signed [AW-1:0]     acc,
    input logic signed [DATA_W-1:0] bias
  );
    logic signed [AW-1:0] bias_ext;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] sh;
    bias_ext = {{(AW-DATA_W){bias[DATA_W-1]}}, bias};
    sum      = acc + (bias_ext <<< FRAC_W);
    sh       = sum >>> FRAC_W;
    if (sh > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (sh < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return sh[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
    return (v < 0) ? '0 : v;
  endfunction

  state_t                    state_q, state_d;
  logic signed [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]             in_cnt_q, in_cnt_d;
  logic [CW-1:0]             nrn_cnt_q, nrn_cnt_d;
  logic signed [DATA_W-1:0]  h_q [S];
  logic signed [DATA_W-1:0]  h_d [S];
  logic signed [DATA_W-1:0]  o_q [T];
  logic signed [DATA_W-1:0]  o_d [T];
  logic signed [DATA_W-1:0]  best_val_q, best_val_d;
  logic [3:0]                best_idx_q, best_idx_d;
  logic                      finished_q, finished_d;
  logic [3:0]                result_q, result_d;

  logic signed [DATA_W-1:0]  mac_a, mac_b, o_cur, fin_val;
  logic signed [PW-1:0]      prod;
  logic signed [AW-1:0]      prod_ext;
  logic signed [DATA_W-1:0]  cand_val;
  logic [3:0]                cand_idx;

  // Operand muxes: L1 walks x against W1, L2 walks h against the current W2 row.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    o_cur = '0;
    if (state_q == S_L1) begin
      mac_b = W1_VAL;
      for (int i = 0; i < F; i++)
        if (in_cnt_q == CW'(i)) mac_a = x_rom(i);
    end else if (state_q == S_L2) begin
      for (int j = 0; j < S; j++)
        if (in_cnt_q == CW'(j)) mac_a = h_q[j];
      for (int k = 0; k < T; k++)
        if (nrn_cnt_q == CW'(k)) mac_b = w2_rom(k);
    end
    for (int k = 0; k < T; k++)
      if (nrn_cnt_q == CW'(k)) o_cur = o_q[k];
  end

  assign prod     = mac_a * mac_b;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    in_cnt_d   = in_cnt_q;
    nrn_cnt_d  = nrn_cnt_q;
    h_d        = h_q;
    o_d        = o_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    finished_d = finished_q;
    result_d   = result_q;
    fin_val    = '0;
    cand_val   = best_val_q;
    cand_idx   = best_idx_q;
    case (state_q)
      S_IDLE: begin
        finished_d = 1'b0;
        if (enable) begin
          state_d   = S_L1;
          acc_d     = '0;
          in_cnt_d  = '0;
          nrn_cnt_d = '0;
        end
      end
      S_L1: begin
        if (in_cnt_q != CW'(F)) begin
          acc_d    = acc_q + prod_ext;
          in_cnt_d = in_cnt_q + 1'b1;
        end else begin
          fin_val = relu(bias_shift_sat(acc_q, B1_VAL));
          for (int j = 0; j < S; j++)
            if (nrn_cnt_q == CW'(j)) h_d[j] = fin_val;
          acc_d    = '0;
          in_cnt_d = '0;
          if (nrn_cnt_q == CW'(S - 1)) begin
            nrn_cnt_d = '0;
            state_d   = S_L2;
          end else begin
            nrn_cnt_d = nrn_cnt_q + 1'b1;
          end
        end
      end
      S_L2: begin
        if (in_cnt_q != CW'(S)) begin
          acc_d    = acc_q + prod_ext;
          in_cnt_d = in_cnt_q + 1'b1;
        end else begin
          fin_val = bias_shift_sat(acc_q, B2_VAL);
          for (int k = 0; k < T; k++)
            if (nrn_cnt_q == CW'(k)) o_d[k] = fin_val;
          acc_d    = '0;
          in_cnt_d = '0;
          if (nrn_cnt_q == CW'(T - 1)) begin
            nrn_cnt_d = '0;
            state_d   = S_ARG;
          end else begin
            nrn_cnt_d = nrn_cnt_q + 1'b1;
          end
        end
      end
      S_ARG: begin
        // Strictly-greater replacement keeps the lowest index on ties.
        if (nrn_cnt_q == '0 || o_cur > best_val_q) begin
          cand_val = o_cur;
          cand_idx = nrn_cnt_q[3:0];
        end
        best_val_d = cand_val;
        best_idx_d = cand_idx;
        if (nrn_cnt_q == CW'(T - 1)) begin
          result_d   = cand_idx;
          finished_d = 1'b1;
          nrn_cnt_d  = '0;
          state_d    = S_DONE;
        end else begin
          nrn_cnt_d = nrn_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_d    = S_IDLE;
          finished_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      in_cnt_q   <= '0;
      nrn_cnt_q  <= '0;
      for (int j = 0; j < S; j++) h_q[j] <= '0;
      for (int k = 0; k < T; k++) o_q[k] <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      finished_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      in_cnt_q   <= in_cnt_d;
      nrn_cnt_q  <= nrn_cnt_d;
      h_q        <= h_d;
      o_q        <= o_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      finished_q <= finished_d;
      result_q   <= result_d;
    end
  end

  assign finished = finished_q;
  assign result   = result_q;

endmodule

// File: tb/tb_fc_net_main.sv
// Directed bench for fc_net_main: default ROMs plus two W2-override builds (dominant row 7, tie 3/5).
module tb_fc_net_main;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       fin0, fin1, fin2;
  logic [3:0] res0, res1, res2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_net_main u_dut (
    .clk(clk), .reset(reset), .enable(enable), .finished(fin0), .result(res0)
  );

  // Row 7 of W2 = 4.0 gives o[7] = 48.0 against o[0] = 30.0.
  fc_net_main #(.W2_OVR_MASK(128), .W2_OVR_VAL(16'sh0400)) u_top7 (
    .clk(clk), .reset(reset), .enable(enable), .finished(fin1), .result(res1)
  );

  // Rows 3 and 5 both 4.0: equal maxima, lowest index wins.
  fc_net_main #(.W2_OVR_MASK(40), .W2_OVR_VAL(16'sh0400)) u_tie (
    .clk(clk), .reset(reset), .enable(enable), .finished(fin2), .result(res2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the start edge; optionally pulses enable low for one edge.
  task automatic check_run(input string tag, input int pulse_cyc);
    logic early;
    early = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      @(posedge clk);
      #1;
      if (c < 48 && (fin0 || fin1 || fin2)) early = 1'b1;
      if (c == pulse_cyc) enable = 1'b0;
      if (c == pulse_cyc + 1) enable = 1'b1;
    end
    chk({tag, "_no_early_finish"}, 32'(early), 32'd0);
    chk({tag, "_finished_at_48"}, 32'(fin0), 32'd1);
    chk({tag, "_result_default"}, 32'(res0), 32'd0);
    chk({tag, "_result_row7"}, 32'(res1), 32'd7);
    chk({tag, "_result_tie"}, 32'(res2), 32'd3);
  endtask

  task automatic end_run(input string tag);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_finished_drop"}, 32'(fin0), 32'd0);
    chk({tag, "_result_hold_default"}, 32'(res0), 32'd0);
    chk({tag, "_result_hold_row7"}, 32'(res1), 32'd7);
  endtask

  initial begin
    logic seen;
    reset  = 1'b0;
    enable = 1'b1;

    repeat (5) @(negedge clk);
    chk("rst_finished", 32'(fin0), 32'd0);
    chk("rst_result", 32'(res0), 32'd0);
    repeat (5) @(negedge clk);
    chk("rst_result_row7", 32'(res1), 32'd0);
    reset  = 1'b1;
    enable = 1'b0;

    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (fin0) seen = 1'b1;
    end
    chk("idle_no_finish", 32'(seen), 32'd0);

    start_run();
    check_run("run1", -10);

    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (!fin0) seen = 1'b1;
    end
    chk("done_hold_while_enable", 32'(seen), 32'd0);

    end_run("drop1");
    start_run();
    check_run("run2", -10);

    end_run("drop2");
    start_run();
    check_run("pulse", 20);

    end_run("drop3");
    start_run();
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
    end
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    chk("abort_finished", 32'(fin0), 32'd0);
    chk("abort_result", 32'(res0), 32'd0);
    chk("abort_result_row7", 32'(res1), 32'd0);
    chk("abort_result_tie", 32'(res2), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    start_run();
    check_run("after_abort", -10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_net_main.md
Name: fc_net_main

Overview:
- Self-contained, two-stage fully-connected classifier: input vector → hidden layer (ReLU) → output layer → argmax.
- Input vector, weights and biases live in internal constant ROMs; no external data path.
- Sits at the back end of the DCNN accelerator.
- On `enable` it runs one inference with a single sequential MAC unit, then reports the class index on `result` with `finished` high.

Parameters:
- firstLayerNodes, 3: input vector length F (≥1).
- secondLayerNodes, 2: hidden neuron count S (≥1).
- thirdLayerNodes, 10: output neuron / class count T (2..16).
- DATA_W, 16: signed fixed-point word width.
- FRAC_W, 8: fractional bits (Q8.8 at defaults).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  start request / hold-done.
- finished  output  1  inference complete; result valid.
- result  output  4  argmax class index.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, finished=0, result=0, accumulators and counters cleared.
- Default ROM contents (all Q8.8, used when nothing else is loaded):
  - x[i] = i+1.
  - W1[j][i] = 1.0; b1 = 0.
  - W2[k][j] = (T−k)·0.25; b2 = 0.
  - With default parameters the expected result is 0.
- States: IDLE → L1 → L2 → ARGMAX → DONE.
- IDLE: when enable=1 at a rising edge, clear the accumulator and neuron/input counters, go to L1.
- L1, per hidden neuron j:
  - F cycles: acc += x[i]·W1[j][i].
  - 1 finalize cycle: h[j] = ReLU(sat((acc + (b1[j]<<FRAC_W)) >>> FRAC_W)), then clear acc.
  - After neuron S−1, go to L2.
- L2, per output neuron k:
  - S cycles MAC over h.
  - 1 finalize cycle, same as L1 but without ReLU, storing o[k].
  - After neuron T−1, go to ARGMAX.
- ARGMAX: T cycles scanning o[0..T−1]; replace the best only on strictly greater, so ties resolve to the lowest index. At the end, register result and go to DONE.
- DONE: finished=1. Stay while enable=1. When enable=0, go to IDLE, finished=0, result holds its value.
- Latency: finished rises on rising edge N = S·(F+1) + T·(S+1) + T after the IDLE start edge. Default N = 8 + 30 + 10 = 48.
- enable is sampled only in IDLE and DONE. Deassertion during L1/L2/ARGMAX is ignored and the run completes.
- Arithmetic:
  - Products are 2·DATA_W signed.
  - Accumulator is 2·DATA_W+8 signed.
  - Shift is arithmetic.
  - Saturate to the signed DATA_W range [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Reset asserted mid-run aborts immediately to the reset state. A new run needs enable=1 after reset is released.
- finished and result are registered outputs, glitch-free.

Test Plan:
- Defaults, reset=0 for 100 ns then reset=1, enable=1 → finished rises exactly 48 cycles after the start edge, result=0. finished stays 1 while enable=1.
- Reset check: during reset=0, finished=0 and result=0 irrespective of clk or enable.
- enable held 0 after reset → state stays IDLE, finished never asserts.
- Drop enable in DONE, then re-raise it → finished falls within 1 cycle, result holds 0; second run again yields finished after 48 cycles with result=0.
- Pulse enable low at cycle 20 of a run → run completes, finished at cycle 48 with result=0.
- Assert reset=0 at cycle 30 of a run → finished=0 and result=0 immediately. Release reset and enable again → full 48-cycle run, result=0.
- Override ROM so that W2[7][*] is largest, and a second case with a tie between classes 3 and 5 → result=7, and result=3 for the tie.
